mips_control_multicycle_fsm: RTL and testbench

Multicycle successor to the single-cycle main decoder. A state machine sequences each instruction through fetch/decode/execute/memory/writeback, issuing per-state datapath controls. It adds a memory-ready handshake, a configurable instruction set (addi, bne), illegal-opcode signalling and a retired-instruction counter. It sits between the instruction register's opcode field and the shared multicycle datapath (PC, IR, register file, ALU, unified memory).

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/mips_ctrl_output_decode.sv | 86 ++++++++
 rtl/mips_control_multicycle_fsm.sv | 125 ++++++++++++
 tb/tb_mips_control_multicycle_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Opcodes, FSM states, ALU-op / operand-select codes and the packed control word.
// Pure declarations; no logic.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       is_signed;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Per-state control word decode for the multicycle MIPS datapath.
// Latency: purely combinational.
// Backpressure: FETCH PC/IR loads are qualified by mem_ready; everything else is state-only.
module mips_ctrl_output_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [3:0]          state,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] op_code,
  output logic [CTRL_W-1:0]   ctrl_word
);

  localparam logic [OPCODE_W-1:0] C_BNE = OPCODE_W'(OP_BNE);

  ctrl_t c;

  assign ctrl_word = c;

  // Map each state to its datapath controls; anything not set stays 0.
  always_comb begin
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_write  = mem_ready;
        c.ir_write  = mem_ready;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_ADR, S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        c.is_signed = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        // Only beq/bne reach BRANCH, so anything not bne is beq.
        c.branch_ne = (op_code == C_BNE);
        c.branch    = (op_code != C_BNE);
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      S_ILLEGAL: begin
        c.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_multicycle_fsm.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Latency: lw 5, sw/R/addi 4, beq/bne/j 3 cycles when memory is ready; controls are combinational from state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until i_mem_ready.
module mips_control_multicycle_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 32,
  parameter int EN_ADDI  = 1,
  parameter int EN_BNE   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [OPCODE_W-1:0] i_op_code,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_branch,
  output logic                o_branch_ne,
  output logic                o_iord,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [1:0]          o_pc_src,
  output logic                o_is_signed,
  output logic                o_illegal_op,
  output logic [CNT_W-1:0]    o_instr_cnt,
  output logic [3:0]          o_state
);

  localparam logic [OPCODE_W-1:0] C_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] C_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] C_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] C_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] C_BNE   = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] C_J     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  // Next-state sequencing and retire detection.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (i_mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if      (i_op_code == C_RTYPE)                state_nxt = S_R_EXEC;
        else if (i_op_code == C_LW || i_op_code == C_SW) state_nxt = S_MEM_ADR;
        else if (i_op_code == C_BEQ)                  state_nxt = S_BRANCH;
        else if (i_op_code == C_BNE && EN_BNE != 0)   state_nxt = S_BRANCH;
        else if (i_op_code == C_J)                    state_nxt = S_JUMP;
        else if (i_op_code == C_ADDI && EN_ADDI != 0) state_nxt = S_ADDI_EXEC;
        else                                          state_nxt = S_ILLEGAL;
      end
      // IR is stable here, so lw/sw is resolved from the live opcode.
      S_MEM_ADR: state_nxt = (i_op_code == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (i_mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR: begin
        if (i_mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_R_EXEC:    state_nxt = S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Retired-instruction counter; illegal opcodes never count, wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  mips_ctrl_output_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_output_decode (
    .state     (state),
    .mem_ready (i_mem_ready),
    .op_code   (i_op_code),
    .ctrl_word (ctrl)
  );

  assign o_pc_write   = ctrl.pc_write;
  assign o_branch     = ctrl.branch;
  assign o_branch_ne  = ctrl.branch_ne;
  assign o_iord       = ctrl.iord;
  assign o_mem_read   = ctrl.mem_read;
  assign o_mem_write  = ctrl.mem_write;
  assign o_ir_write   = ctrl.ir_write;
  assign o_reg_dst    = ctrl.reg_dst;
  assign o_mem_to_reg = ctrl.mem_to_reg;
  assign o_reg_write  = ctrl.reg_write;
  assign o_alu_src_a  = ctrl.alu_src_a;
  assign o_alu_src_b  = ctrl.alu_src_b;
  assign o_alu_op     = ALU_OP_W'(ctrl.alu_op);
  assign o_pc_src     = ctrl.pc_src;
  assign o_is_signed  = ctrl.is_signed;
  assign o_illegal_op = ctrl.illegal_op;
  assign o_instr_cnt  = instr_cnt;
  assign o_state      = state;

endmodule

// File: tb/tb_mips_control_multicycle_fsm.sv
// Bench for mips_control_multicycle_fsm: directed table, corner sequences, random instruction stream.
// Two instances: A = full ISA, 32-bit counter; B = no addi/bne, 4-bit counter.
// Expected per-cycle controls come from an instruction-level schedule model.
module tb_mips_control_multicycle_fsm;
  import mips_ctrl_pkg::*;

  localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_BEQ = 3, CL_BNE = 4,
                 CL_J = 5, CL_ADDI = 6, CL_ILL = 7;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] w;
    logic [31:0] cnt;
  } vec_t;

  logic        clk, rst_n;
  logic [5:0]  op_a, op_b;
  logic        rdy_a, rdy_b;
  wire  [18:0] w_a, w_b;
  wire  [3:0]  st_a, st_b;
  wire  [31:0] cnt_a;
  wire  [3:0]  cnt_b;

  int          total, bad;
  logic [31:0] cnt_exp  [2];
  logic [31:0] cnt_mask [2];
  bit          en_addi  [2];
  bit          en_bne   [2];
  vec_t        tbl [$];

  logic [18:0] w_dec, w_madr, w_mrd, w_mwb, w_mwr, w_rex, w_rwb;
  logic [18:0] w_beq, w_bne, w_jmp, w_aex, w_awb, w_ill;

  mips_control_multicycle_fsm u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_code(op_a), .i_mem_ready(rdy_a),
    .o_pc_write(w_a[18]), .o_branch(w_a[17]), .o_branch_ne(w_a[16]), .o_iord(w_a[15]),
    .o_mem_read(w_a[14]), .o_mem_write(w_a[13]), .o_ir_write(w_a[12]), .o_reg_dst(w_a[11]),
    .o_mem_to_reg(w_a[10]), .o_reg_write(w_a[9]), .o_alu_src_a(w_a[8]), .o_alu_src_b(w_a[7:6]),
    .o_alu_op(w_a[5:4]), .o_pc_src(w_a[3:2]), .o_is_signed(w_a[1]), .o_illegal_op(w_a[0]),
    .o_instr_cnt(cnt_a), .o_state(st_a)
  );

  mips_control_multicycle_fsm #(.CNT_W(4), .EN_ADDI(0), .EN_BNE(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_op_code(op_b), .i_mem_ready(rdy_b),
    .o_pc_write(w_b[18]), .o_branch(w_b[17]), .o_branch_ne(w_b[16]), .o_iord(w_b[15]),
    .o_mem_read(w_b[14]), .o_mem_write(w_b[13]), .o_ir_write(w_b[12]), .o_reg_dst(w_b[11]),
    .o_mem_to_reg(w_b[10]), .o_reg_write(w_b[9]), .o_alu_src_a(w_b[8]), .o_alu_src_b(w_b[7:6]),
    .o_alu_op(w_b[5:4]), .o_pc_src(w_b[3:2]), .o_is_signed(w_b[1]), .o_illegal_op(w_b[0]),
    .o_instr_cnt(cnt_b), .o_state(st_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [18:0] mk(logic pcw, br, brn, iord, mr, mw, irw, rd, m2r, rw, sa,
                                     logic [1:0] sb, ao, ps, logic sg, il);
    return {pcw, br, brn, iord, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, sg, il};
  endfunction

  function automatic logic [18:0] w_fetch(logic r);
    return mk(r,0,0,0,1,0,r,0,0,0,0, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction

  function automatic vec_t mkv(logic [5:0] op, logic r, logic [3:0] st, logic [18:0] w, int c);
    vec_t v;
    v.op = op; v.rdy = r; v.st = st; v.w = w; v.cnt = 32'(c);
    return v;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(int d, logic [5:0] op);
    if (op == OP_RTYPE)             return CL_R;
    if (op == OP_LW)                return CL_LW;
    if (op == OP_SW)                return CL_SW;
    if (op == OP_BEQ)               return CL_BEQ;
    if (op == OP_BNE && en_bne[d])  return CL_BNE;
    if (op == OP_J)                 return CL_J;
    if (op == OP_ADDI && en_addi[d]) return CL_ADDI;
    return CL_ILL;
  endfunction

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d t=%0t got=%h want=%h", name, d, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare before the next rising edge, then advance.
  task automatic step(int d, logic [5:0] op, logic r, logic [3:0] st, logic [18:0] w);
    logic [18:0] aw;
    logic [3:0]  ast;
    logic [31:0] acnt;
    if (d == 0) begin op_a = op; rdy_a = r; rdy_b = 1'b0; end
    else        begin op_b = op; rdy_b = r; rdy_a = 1'b0; end
    #1;
    aw   = (d == 0) ? w_a   : w_b;
    ast  = (d == 0) ? st_a  : st_b;
    acnt = (d == 0) ? cnt_a : {28'b0, cnt_b};
    check("state", d, {28'b0, ast}, {28'b0, st});
    check("ctrl", d, {13'b0, aw}, {13'b0, w});
    check("cnt", d, acnt, cnt_exp[d]);
    check("excl", d, {31'b0, (aw[14] & aw[13]) | (aw[9] & aw[13])}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: expand one instruction into its cycle schedule.
  task automatic run_instr(int d, logic [5:0] op, int fstall, int mstall);
    int cls;
    cls = classify(d, op);
    for (int i = 0; i < fstall; i++) step(d, op, 1'b0, S_FETCH, w_fetch(1'b0));
    step(d, op, 1'b1, S_FETCH, w_fetch(1'b1));
    step(d, op, rb(), S_DECODE, w_dec);
    case (cls)
      CL_LW: begin
        step(d, op, rb(), S_MEM_ADR, w_madr);
        for (int i = 0; i < mstall; i++) step(d, op, 1'b0, S_MEM_RD, w_mrd);
        step(d, op, 1'b1, S_MEM_RD, w_mrd);
        step(d, op, rb(), S_MEM_WB, w_mwb);
      end
      CL_SW: begin
        step(d, op, rb(), S_MEM_ADR, w_madr);
        for (int i = 0; i < mstall; i++) step(d, op, 1'b0, S_MEM_WR, w_mwr);
        step(d, op, 1'b1, S_MEM_WR, w_mwr);
      end
      CL_R: begin
        step(d, op, rb(), S_R_EXEC, w_rex);
        step(d, op, rb(), S_R_WB, w_rwb);
      end
      CL_BEQ:  step(d, op, rb(), S_BRANCH, w_beq);
      CL_BNE:  step(d, op, rb(), S_BRANCH, w_bne);
      CL_J:    step(d, op, rb(), S_JUMP, w_jmp);
      CL_ADDI: begin
        step(d, op, rb(), S_ADDI_EXEC, w_aex);
        step(d, op, rb(), S_ADDI_WB, w_awb);
      end
      default: step(d, op, rb(), S_ILLEGAL, w_ill);
    endcase
    if (cls != CL_ILL) cnt_exp[d] = (cnt_exp[d] + 32'd1) & cnt_mask[d];
  endtask

  initial begin
    total = 0; bad = 0;
    cnt_exp[0] = 0; cnt_exp[1] = 0;
    cnt_mask[0] = 32'hFFFF_FFFF; cnt_mask[1] = 32'h0000_000F;
    en_addi[0] = 1; en_bne[0] = 1; en_addi[1] = 0; en_bne[1] = 0;

    w_dec  = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0, 0);
    w_madr = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 1, 0);
    w_mrd  = mk(0,0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0);
    w_mwb  = mk(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    w_mwr  = mk(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0);
    w_rex  = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0, 0);
    w_rwb  = mk(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    w_beq  = mk(0,1,0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0, 0);
    w_bne  = mk(0,0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0, 0);
    w_jmp  = mk(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0, 0);
    w_aex  = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 1, 0);
    w_awb  = mk(0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0);
    w_ill  = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 1);

    // Directed stream from reset, memory always ready.
    tbl.push_back(mkv(OP_LW,    1, S_FETCH,     w_fetch(1'b1), 0));
    tbl.push_back(mkv(OP_LW,    1, S_DECODE,    w_dec,  0));
    tbl.push_back(mkv(OP_LW,    1, S_MEM_ADR,   w_madr, 0));
    tbl.push_back(mkv(OP_LW,    1, S_MEM_RD,    w_mrd,  0));
    tbl.push_back(mkv(OP_LW,    1, S_MEM_WB,    w_mwb,  0));
    tbl.push_back(mkv(OP_SW,    1, S_FETCH,     w_fetch(1'b1), 1));
    tbl.push_back(mkv(OP_SW,    1, S_DECODE,    w_dec,  1));
    tbl.push_back(mkv(OP_SW,    1, S_MEM_ADR,   w_madr, 1));
    tbl.push_back(mkv(OP_SW,    1, S_MEM_WR,    w_mwr,  1));
    tbl.push_back(mkv(OP_RTYPE, 1, S_FETCH,     w_fetch(1'b1), 2));
    tbl.push_back(mkv(OP_RTYPE, 1, S_DECODE,    w_dec,  2));
    tbl.push_back(mkv(OP_RTYPE, 1, S_R_EXEC,    w_rex,  2));
    tbl.push_back(mkv(OP_RTYPE, 1, S_R_WB,      w_rwb,  2));
    tbl.push_back(mkv(OP_BEQ,   1, S_FETCH,     w_fetch(1'b1), 3));
    tbl.push_back(mkv(OP_BEQ,   1, S_DECODE,    w_dec,  3));
    tbl.push_back(mkv(OP_BEQ,   1, S_BRANCH,    w_beq,  3));
    tbl.push_back(mkv(OP_BNE,   1, S_FETCH,     w_fetch(1'b1), 4));
    tbl.push_back(mkv(OP_BNE,   1, S_DECODE,    w_dec,  4));
    tbl.push_back(mkv(OP_BNE,   1, S_BRANCH,    w_bne,  4));
    tbl.push_back(mkv(OP_J,     1, S_FETCH,     w_fetch(1'b1), 5));
    tbl.push_back(mkv(OP_J,     1, S_DECODE,    w_dec,  5));
    tbl.push_back(mkv(OP_J,     1, S_JUMP,      w_jmp,  5));
    tbl.push_back(mkv(OP_ADDI,  1, S_FETCH,     w_fetch(1'b1), 6));
    tbl.push_back(mkv(OP_ADDI,  1, S_DECODE,    w_dec,  6));
    tbl.push_back(mkv(OP_ADDI,  1, S_ADDI_EXEC, w_aex,  6));
    tbl.push_back(mkv(OP_ADDI,  1, S_ADDI_WB,   w_awb,  6));
    tbl.push_back(mkv(OP_J,     0, S_FETCH,     w_fetch(1'b0), 7));

    // Reset state.
    rst_n = 1'b0; op_a = '0; op_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
    #12;
    check("rst_state", 0, {28'b0, st_a}, {28'b0, 4'(S_FETCH)});
    check("rst_cnt", 0, cnt_a, 32'd0);
    check("rst_ctrl", 0, {13'b0, w_a}, {13'b0, w_fetch(1'b0)});
    check("rst_state", 1, {28'b0, st_b}, {28'b0, 4'(S_FETCH)});
    check("rst_cnt", 1, {28'b0, cnt_b}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cnt_exp[0] = tbl[i].cnt;
      step(0, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].w);
    end
    cnt_exp[0] = 32'd7;

    // Reset asserted while lw waits in MEM_RD.
    step(0, OP_LW, 1'b1, S_FETCH, w_fetch(1'b1));
    step(0, OP_LW, 1'b1, S_DECODE, w_dec);
    step(0, OP_LW, 1'b1, S_MEM_ADR, w_madr);
    rdy_a = 1'b0;
    #1;
    check("mrd_state", 0, {28'b0, st_a}, {28'b0, 4'(S_MEM_RD)});
    rst_n = 1'b0;
    #1;
    check("midrst_state", 0, {28'b0, st_a}, {28'b0, 4'(S_FETCH)});
    check("midrst_cnt", 0, cnt_a, 32'd0);
    check("midrst_ctrl", 0, {13'b0, w_a}, {13'b0, w_fetch(1'b0)});
    rst_n = 1'b1;
    cnt_exp[0] = 0; cnt_exp[1] = 0;
    @(posedge clk);
    #1;

    // sw with three wait cycles in MEM_WR: four mem_write cycles, one retire.
    run_instr(0, OP_SW, 0, 3);
    check("sw_stall_cnt", 0, cnt_a, 32'd1);

    // Random instruction stream with random fetch/memory stalls.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 7))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_BNE;
        5: op = OP_J;
        6: op = OP_ADDI;
        default: op = 6'($urandom);
      endcase
      run_instr(0, op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Instance B: unsupported opcodes go ILLEGAL without counting.
    run_instr(1, 6'b111111, 0, 0);
    run_instr(1, OP_ADDI, 1, 0);
    run_instr(1, OP_BNE, 0, 0);
    check("ill_cnt", 1, {28'b0, cnt_b}, 32'd0);

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int n = 0; n < 16; n++) run_instr(1, OP_J, 0, 0);
    check("wrap_cnt", 1, {28'b0, cnt_b}, 32'd0);
    run_instr(1, OP_BEQ, 0, 0);
    check("post_wrap_cnt", 1, {28'b0, cnt_b}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 1) == 0) ? 6'($urandom) : OP_LW;
      run_instr(1, op, $urandom_range(0, 1), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
